data_mem_mmio: RTL and testbench
================================

// Module: data_mem_mmio
// PURPOSE
//  Data-side memory stage fed by the single-cycle RV32I core: consumes the core's aluResult (address), rd2
//  (store data) and memWrite, and returns readData in the same cycle for loads.
//  Word RAM plus a small MMIO window: GPIO output register, free-running cycle counter, compare timer
//  with sticky match flag. Word access only (lw/sw); no byte lanes.
// PARAMETERS
//  DEPTH      32            RAM size in 32-bit words; power of two, 2..1024
//  MMIO_BASE  32'h0000_FF00 base byte address of 16-byte MMIO window (aligned to 256)
// PORTS
//  clk        in   1   single clock, all state updates on posedge
//  reset      in   1   synchronous, active-high
//  memWrite   in   1   store strobe from core
//  addr       in   32  byte address (core aluResult)
//  writeData  in   32  store data (core rd2)
//  readData   out  32  load data, combinational from addr
//  gpioOut    out  32  GPIO output register
//  timerIrq   out  1   level = sticky match flag
// BEHAVIOUR
//  Reset: synchronous, active-high; one clock; gpioOut=0, cycle counter=0, compare=32'hFFFF_FFFF,
//   match flag=0 (timerIrq=0). RAM contents are NOT reset.
//  Decode (combinational): addr[1:0] ignored (no misalign trap).
//   MMIO hit: addr[31:8]==MMIO_BASE[31:8] && addr[7:4]==0. Offset = addr[3:2].
//   RAM hit: addr[31:12]==0 and not MMIO hit; index = addr[$clog2(DEPTH)+1:2] (aliases wrap mod DEPTH).
//   Neither: reads return 0, writes dropped.
//  RAM: read combinational (zero latency); write on posedge when memWrite && RAM hit;
//   same-cycle read of the written word returns OLD data; new data is visible the next cycle.
//  MMIO map (offset: name, read / write effect at posedge):
//   0x0 GPIO    RW, gpioOut <= writeData
//   0x4 CYCLE   R = counter; any write clears to 0 (write data ignored)
//   0x8 CMP     RW, compare <= writeData
//   0xC STATUS  R = {31'b0,match}; write with writeData[0]=1 clears match, [0]=0 no effect
//  Counter: +1 every cycle out of reset, wraps 32'hFFFF_FFFF -> 0 silently.
//   Write-clear and increment in same cycle: clear wins (counter=0 next cycle, 1 the cycle after).
//  Match: when counter==compare (pre-increment value), match<=1 at that posedge; stays set until cleared.
//   Set and clear in same cycle: set wins.
//   A CMP write takes effect for the comparison from the next cycle.
//  Reset asserted mid-operation: all MMIO state returns to reset values on that edge; a concurrent
//   store to RAM is still performed (RAM write not gated by reset); MMIO stores are discarded.
//  timerIrq = match, registered output, no combinational path from inputs.
// STRUCTURE
//  mem_map_pkg: MMIO offset localparams (OFF_GPIO..OFF_STATUS), CMP_RESET value, typedef enum for the
//   decoded region {REG_RAM, REG_MMIO, REG_NONE}.
//  Sub-module mmio_timer: counter, compare, match flag, clear/set priority; top does decode,
//   RAM array, GPIO register and readData mux.
// TESTING
//  Reset, then sw 0xDEADBEEF @0x10, lw @0x10 next cycle -> 0xDEADBEEF; same-cycle read during write -> old value.
//  Alias: DEPTH=32, sw 0x1234 @0x04, lw @0x84 -> 0x1234; lw @0x2000 -> 0; sw @0x2000 changes nothing.
//  GPIO: sw 0xA5 @0xFF00 -> gpioOut==0xA5 after edge; lw @0xFF00 -> 0xA5; reset -> gpioOut==0.
//  Timer: reset, CMP=5 -> timerIrq rises at edge where counter 5->6 and holds; STATUS=1 clears it;
//   clear while counter==CMP -> timerIrq stays 1.
//  Counter: write CYCLE -> next read 0; force counter 32'hFFFF_FFFF -> wraps to 0, no irq unless CMP==0xFFFF_FFFF.
//  Reset mid-run with pending match and GPIO=0xFF -> all MMIO reset values next cycle, RAM data preserved.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Shared address-map definitions for the data memory stage: MMIO register offsets,
// timer reset values and the decoded access region.
package mem_map_pkg;

  localparam logic [1:0]  OFF_GPIO   = 2'd0;
  localparam logic [1:0]  OFF_CYCLE  = 2'd1;
  localparam logic [1:0]  OFF_CMP    = 2'd2;
  localparam logic [1:0]  OFF_STATUS = 2'd3;

  localparam logic [31:0] CMP_RESET  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_MMIO = 2'd1,
    REG_NONE = 2'd2
  } region_e;

  // The MMIO window takes precedence so a base placed inside the low 4 KiB still works.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [23:0] base_hi);
    if ((addr[31:8] == base_hi) && (addr[7:4] == 4'h0)) begin
      return REG_MMIO;
    end else if (addr[31:12] == 20'h0) begin
      return REG_RAM;
    end else begin
      return REG_NONE;
    end
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Free-running cycle counter with a compare register and a sticky match flag.
// Counter clear beats increment; match set beats match clear.
module mmio_timer
  import mem_map_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_cycle_clr,
  input  logic        i_cmp_we,
  input  logic [31:0] i_cmp_wdata,
  input  logic        i_match_clr,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_match
);

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_match;
  logic        w_hit;

  // Comparison uses the pre-increment count and the compare value held this cycle.
  assign w_hit = (r_count == r_compare);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= 32'h0;
      r_compare <= CMP_RESET;
      r_match   <= 1'b0;
    end else begin
      if (i_cycle_clr) begin
        r_count <= 32'h0;
      end else begin
        r_count <= r_count + 32'd1;
      end

      if (i_cmp_we) begin
        r_compare <= i_cmp_wdata;
      end

      if (w_hit) begin
        r_match <= 1'b1;
      end else if (i_match_clr) begin
        r_match <= 1'b0;
      end
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_match   = r_match;

endmodule

// File: rtl/data_mem_mmio.sv
// Data-side memory stage for the single-cycle RV32I core: word RAM with zero-latency
// reads plus a 16-byte MMIO window (GPIO, cycle counter, compare timer, status).
module data_mem_mmio
  import mem_map_pkg::*;
#(
  parameter int          DEPTH     = 32,
  parameter logic [31:0] MMIO_BASE = 32'h0000_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memWrite,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic [31:0] gpioOut,
  output logic        timerIrq
);

  localparam int AW = $clog2(DEPTH);

  region_e       w_region;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_off;
  logic          w_ram_we;
  logic          w_mmio_we;
  logic [31:0]   w_count;
  logic [31:0]   w_compare;
  logic          w_match;

  logic [31:0]   r_ram [DEPTH];
  logic [31:0]   r_gpio;

  assign w_region  = decode_region(addr, MMIO_BASE[31:8]);
  assign w_idx     = addr[AW+1:2];
  assign w_off     = addr[3:2];
  assign w_ram_we  = memWrite && (w_region == REG_RAM);
  assign w_mmio_we = memWrite && (w_region == REG_MMIO);

  // RAM stores deliberately ignore reset so a store in flight during reset still lands.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_ram[w_idx] <= writeData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gpio <= 32'h0;
    end else if (w_mmio_we && (w_off == OFF_GPIO)) begin
      r_gpio <= writeData;
    end
  end

  mmio_timer u_timer (
    .clk         (clk),
    .reset       (reset),
    .i_cycle_clr (w_mmio_we && (w_off == OFF_CYCLE)),
    .i_cmp_we    (w_mmio_we && (w_off == OFF_CMP)),
    .i_cmp_wdata (writeData),
    .i_match_clr (w_mmio_we && (w_off == OFF_STATUS) && writeData[0]),
    .o_count     (w_count),
    .o_compare   (w_compare),
    .o_match     (w_match)
  );

  always_comb begin
    readData = 32'h0;
    case (w_region)
      REG_RAM: readData = r_ram[w_idx];
      REG_MMIO: begin
        case (w_off)
          OFF_GPIO:   readData = r_gpio;
          OFF_CYCLE:  readData = w_count;
          OFF_CMP:    readData = w_compare;
          OFF_STATUS: readData = {31'b0, w_match};
          default:    readData = 32'h0;
        endcase
      end
      default: readData = 32'h0;
    endcase
  end

  assign gpioOut  = r_gpio;
  assign timerIrq = w_match;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Randomized bench for data_mem_mmio against an address-map level reference model,
// plus directed scenarios for RAM, aliasing, GPIO, timer and reset behaviour.
module tb_data_mem_mmio;

  localparam logic [31:0] BASE = 32'h0000_FF00;
  localparam int          DEP  = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memWrite = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] writeData = 32'h0;
  logic [31:0] readData;
  logic [31:0] gpioOut;
  logic        timerIrq;

  always #5 clk = ~clk;

  data_mem_mmio #(.DEPTH(DEP), .MMIO_BASE(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .memWrite  (memWrite),
    .addr      (addr),
    .writeData (writeData),
    .readData  (readData),
    .gpioOut   (gpioOut),
    .timerIrq  (timerIrq)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] m_ram [DEP];
  bit          m_known [DEP];
  logic [31:0] m_gpio  = 32'h0;
  logic [31:0] m_cnt   = 32'h0;
  logic [31:0] m_cmp   = 32'hFFFF_FFFF;
  bit          m_match = 1'b0;
  logic [31:0] exp_q [$];

  function automatic bit in_mmio(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd16);
  endfunction

  function automatic bit in_ram(input logic [31:0] a);
    return !in_mmio(a) && (a < 32'h1000);
  endfunction

  function automatic int ram_slot(input logic [31:0] a);
    return int'((a / 4) % DEP);
  endfunction

  function automatic int mmio_reg(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  // Returns 0 in known when the location is RAM that was never written.
  function automatic logic [31:0] model_read(input logic [31:0] a, output bit known);
    known = 1'b1;
    if (in_mmio(a)) begin
      case (mmio_reg(a))
        0:       return m_gpio;
        1:       return m_cnt;
        2:       return m_cmp;
        default: return {31'b0, m_match};
      endcase
    end else if (in_ram(a)) begin
      known = m_known[ram_slot(a)];
      return m_ram[ram_slot(a)];
    end
    return 32'h0;
  endfunction

  task automatic model_edge(input bit rst, input bit we, input logic [31:0] a, input logic [31:0] d);
    bit mw;
    mw = we && in_mmio(a);
    if (we && in_ram(a)) begin
      m_ram[ram_slot(a)]   = d;
      m_known[ram_slot(a)] = 1'b1;
    end
    if (rst) begin
      m_gpio = 32'h0; m_cnt = 32'h0; m_cmp = 32'hFFFF_FFFF; m_match = 1'b0;
    end else begin
      m_match = (m_cnt == m_cmp) || (m_match && !(mw && mmio_reg(a) == 3 && d[0]));
      m_cnt   = (mw && mmio_reg(a) == 1) ? 32'h0 : m_cnt + 32'd1;
      if (mw && mmio_reg(a) == 2) m_cmp  = d;
      if (mw && mmio_reg(a) == 0) m_gpio = d;
    end
  endtask

  // One bus cycle: drive at negedge, check outputs mid-cycle, advance model at posedge.
  task automatic bus_cycle(input bit rst, input bit we, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] rd);
    bit          known;
    logic [31:0] exp;
    @(negedge clk);
    reset = rst; memWrite = we; addr = a; writeData = d;
    exp = model_read(a, known);
    if (known) exp_q.push_back(exp);
    #1;
    rd = readData;
    if (known) check_eq("rdata", readData, exp_q.pop_front());
    check_eq("gpio", gpioOut, m_gpio);
    check_eq("irq", {31'b0, timerIrq}, {31'b0, m_match});
    @(posedge clk);
    model_edge(rst, we, a, d);
  endtask

  task automatic do_rd(input logic [31:0] a, output logic [31:0] rd);
    bus_cycle(1'b0, 1'b0, a, 32'h0, rd);
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    bus_cycle(1'b0, 1'b1, a, d, rd);
  endtask

  task automatic do_rst();
    logic [31:0] rd;
    bus_cycle(1'b1, 1'b0, 32'h0, 32'h0, rd);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] d;
    bit          we;
    bit          rst;

    for (int i = 0; i < DEP; i++) m_known[i] = 1'b0;

    do_rst();
    do_rst();

    // RAM store/load and read-during-write
    do_wr(32'h10, 32'hDEAD_BEEF);
    do_rd(32'h10, rd);                check_eq("lw_after_sw", rd, 32'hDEAD_BEEF);
    bus_cycle(1'b0, 1'b1, 32'h10, 32'h1111_1111, rd);
    check_eq("old_on_write", rd, 32'hDEAD_BEEF);
    do_rd(32'h10, rd);                check_eq("new_after_write", rd, 32'h1111_1111);

    // Aliasing and out-of-range
    do_wr(32'h04, 32'h0000_1234);
    do_rd(32'h84, rd);                check_eq("alias_read", rd, 32'h0000_1234);
    do_rd(32'h2000, rd);              check_eq("unmapped_read", rd, 32'h0);
    do_wr(32'h2000, 32'hFFFF_FFFF);
    do_rd(32'h04, rd);                check_eq("unmapped_wr_drop", rd, 32'h0000_1234);
    do_rd(32'h2000, rd);              check_eq("unmapped_read2", rd, 32'h0);
    do_rd(32'hFF10, rd);              check_eq("past_window", rd, 32'h0);

    // GPIO
    do_wr(32'hFF00, 32'h0000_00A5);
    do_rd(32'hFF00, rd);              check_eq("gpio_read", rd, 32'h0000_00A5);
    check_eq("gpio_out", gpioOut, 32'h0000_00A5);
    do_rst();
    do_rd(32'hFF00, rd);              check_eq("gpio_reset", gpioOut, 32'h0);

    // Timer: CMP=5 written while counter is 0
    do_rst();
    do_wr(32'hFF08, 32'd5);
    for (int i = 1; i <= 5; i++) begin
      do_rd(32'hFF04, rd);            check_eq("cnt_run", rd, i);
    end
    check_eq("irq_before", {31'b0, timerIrq}, 32'h0);
    do_rd(32'hFF0C, rd);              check_eq("status_set", rd, 32'h1);
    do_wr(32'hFF0C, 32'h2);
    do_rd(32'hFF0C, rd);              check_eq("status_nop_clear", rd, 32'h1);
    do_wr(32'hFF0C, 32'h1);
    do_rd(32'hFF0C, rd);              check_eq("status_cleared", rd, 32'h0);

    // Clear while counter equals compare: set wins
    do_rst();
    do_wr(32'hFF08, 32'd3);
    do_rd(32'hFF04, rd);
    do_rd(32'hFF04, rd);
    do_wr(32'hFF0C, 32'h1);
    do_rd(32'hFF0C, rd);              check_eq("set_beats_clear", rd, 32'h1);

    // Counter write-clear beats increment
    do_wr(32'hFF04, 32'hDEAD_0000);
    do_rd(32'hFF04, rd);              check_eq("cnt_clear", rd, 32'h0);
    do_rd(32'hFF04, rd);              check_eq("cnt_after_clear", rd, 32'h1);

    // Reset mid-run with concurrent RAM store and discarded MMIO store
    do_wr(32'hFF00, 32'h0000_00FF);
    do_wr(32'hFF08, 32'h0);
    do_wr(32'hFF04, 32'h0);
    do_rd(32'hFF0C, rd);
    do_rd(32'hFF0C, rd);              check_eq("pending_match", rd, 32'h1);
    bus_cycle(1'b1, 1'b1, 32'h20, 32'hCAFE_F00D, rd);
    bus_cycle(1'b1, 1'b1, 32'hFF00, 32'h77, rd);
    do_rd(32'hFF04, rd);              check_eq("rst_cnt", rd, 32'h0);
    check_eq("rst_gpio", gpioOut, 32'h0);
    check_eq("rst_irq", {31'b0, timerIrq}, 32'h0);
    do_rd(32'hFF08, rd);              check_eq("rst_cmp", rd, 32'hFFFF_FFFF);
    do_rd(32'h20, rd);                check_eq("ram_store_in_rst", rd, 32'hCAFE_F00D);
    do_rd(32'h10, rd);                check_eq("ram_kept", rd, 32'h1111_1111);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 5))
        0, 1:    a = $urandom_range(0, 32'hFFF);
        2, 3:    a = BASE + $urandom_range(0, 15);
        4:       a = $urandom;
        default: a = BASE + 32'd16 + $urandom_range(0, 32'h1FF);
      endcase
      we  = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 80) == 0);
      d   = $urandom;
      if (in_mmio(a) && mmio_reg(a) == 2) d = m_cnt + $urandom_range(0, 12);
      if (in_mmio(a) && mmio_reg(a) == 1 && $urandom_range(0, 3) != 0) we = 1'b0;
      bus_cycle(rst, we, a, d, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
